tms5220_speech_sequencer: RTL
=============================

// Module: tms5220_speech_sequencer
// PURPOSE
// - Hardware sequencer for the TMS5220 speech chip bus, clocked from the sound CPU E clock.
// - Replaces sound-CPU bit-banging of WSn/RSn through the 6532 port.
// - Buffers queued write/status-read commands in a FIFO and runs the chip's strobe/RDYn handshake.
// - Returns status/read data to the sound CPU side and flags chips that never assert RDYn.
// PARAMETERS
// - FIFO_DEPTH   16   command FIFO entries; power of 2, >=2
// - RDY_TIMEOUT  255  max clk_1_5 cycles in WAIT_RDY before abort; >=4
// PORTS
// - clk_1_5        in   1  sound clock (1.5 MHz enable domain)
// - sound_reset_n  in   1  reset; asynchronous, active-low
// - cmd_valid      in   1  push request
// - cmd_ready      out  1  FIFO not full
// - cmd_read       in   1  1 = status/data read, 0 = write
// - cmd_data       in   8  write byte (ignored for reads)
// - flush          in   1  discard queued, not-yet-started commands
// - rsp_valid      out  1  1-cycle pulse: read completed
// - rsp_data       out  8  captured read byte
// - rsp_err        out  1  qualifies rsp_valid: read aborted by timeout
// - err_clr        in   1  clears timeout_err
// - timeout_err    out  1  sticky: some transaction timed out
// - busy           out  1  FSM not IDLE or FIFO not empty
// - fifo_level     out  $clog2(FIFO_DEPTH)+1  entries queued
// - tms_wsn        out  1  TMS5220 write strobe, active-low
// - tms_rsn        out  1  TMS5220 read strobe, active-low
// - tms_dbus_out   out  8  data to chip
// - tms_dbus_oe    out  1  1 = drive tms_dbus_out
// - tms_dbus_in    in   8  data from chip
// - tms_rdyn       in   1  chip ready, active-low; asynchronous to clk_1_5
// BEHAVIOUR
// - Reset: FSM IDLE; FIFO empty; tms_wsn=tms_rsn=1; tms_dbus_oe=0; tms_dbus_out=0.
// - Reset: rsp_valid=0; rsp_data=0; rsp_err=0; timeout_err=0; cmd_ready=1; busy=0.
// - tms_rdyn passes a 2-flop synchronizer (reset value 1); FSM sees rdy_s only.
// - FIFO entry is {read,data}.
// - Push when cmd_valid&&cmd_ready. Pop on the IDLE->SETUP transition.
// - Push and pop in the same cycle are both honoured. Push while full is dropped; cmd_ready=0 prevents it.
// - flush empties the FIFO next cycle. It has priority over a same-cycle push.
// - flush never interrupts the in-flight transaction.
// - FSM states:
//   - IDLE: FIFO non-empty -> SETUP (pop).
//   - SETUP (1 cycle): latch entry. Write: oe=1 and dbus_out=data. Read: oe=0. Strobes stay high. -> STROBE.
//   - STROBE (1 cycle): assert wsn (write) or rsn (read) low; clear timeout counter. -> WAIT_RDY.
//   - WAIT_RDY: strobe held low; counter++. rdy_s==0 -> HOLD. counter==RDY_TIMEOUT -> ABORT.
//   - HOLD (1 cycle): read captures tms_dbus_in into rsp_data, pulses rsp_valid, rsp_err=0. Strobes released high. -> RECOVER.
//   - ABORT (1 cycle): strobes high; timeout_err<=1. Read pulses rsp_valid with rsp_err=1, rsp_data=8'h00. -> RECOVER.
//   - RECOVER (1 cycle): write keeps oe and data stable (hold time), then drops oe. -> IDLE.
// - Minimum transaction: IDLE + SETUP + STROBE + 1 WAIT_RDY + HOLD + RECOVER = 6 cycles.
// - Sync latency adds 2 cycles after the chip asserts RDYn.
// - Back-to-back: next SETUP begins the cycle after RECOVER->IDLE (IDLE lasts 1 cycle).
// - rdy_s already low at STROBE+1: accepted; HOLD follows immediately.
// - timeout_err: set has priority over a same-cycle err_clr.
// - Async reset mid-transaction: strobes go high and oe low immediately; queued commands are lost.
// - fifo_level wraps never; pointers are $clog2(FIFO_DEPTH) bits plus a wrap bit.
// STRUCTURE
// - sound_pkg: speech_state_t enum (IDLE, SETUP, STROBE, WAIT_RDY, HOLD, ABORT, RECOVER); SPEECH_CMD_W=9.
// - Sub-module speech_cmd_fifo: synchronous FIFO, async active-low reset, flush, level.
// - Top holds the synchronizer, FSM, timeout counter and response registers.
// TESTING
// - Write 8'hA5; model asserts RDYn 3 cycles after wsn low.
//   -> wsn low exactly from STROBE until HOLD; dbus_out=A5 with oe=1 from SETUP through RECOVER.
// - Read; model drives dbus_in=8'h3C and RDYn.
//   -> one rsp_valid pulse, rsp_data=3C, rsp_err=0; oe stays 0 throughout.
// - Model never asserts RDYn, RDY_TIMEOUT=8.
//   -> ABORT after 8 WAIT_RDY cycles; timeout_err=1; read gets rsp_err=1 and rsp_data=00.
//   -> err_clr then clears timeout_err.
// - Push 17 writes with FIFO_DEPTH=16 while the chip stalls.
//   -> cmd_ready=0 at level 16; level correct under same-cycle push+pop; write order preserved.
// - Queue 5 commands, flush during the 2nd WAIT_RDY.
//   -> 2nd completes normally; level=0 next cycle; no further strobes; busy drops after RECOVER.
// - Deassert sound_reset_n while wsn is low.
//   -> wsn=1 and oe=0 asynchronously; after release FSM is IDLE, level=0, timeout_err=0.

Source files
------------

// File: rtl/sound_pkg.sv
// Shared types for the sound-board speech sequencer.
package sound_pkg;

  // One queued command: {read, data}.
  localparam int unsigned SPEECH_CMD_W = 9;

  typedef struct packed {
    logic       read;
    logic [7:0] data;
  } speech_cmd_t;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StStrobe,
    StWaitRdy,
    StHold,
    StAbort,
    StRecover
  } speech_state_t;

endpackage

// File: rtl/speech_cmd_fifo.sv
// Command FIFO for the speech sequencer: synchronous, with flush and fill level.
module speech_cmd_fifo
  import sound_pkg::*;
#(
  parameter int unsigned Depth = 16
) (
  input  logic                     clk_1_5,
  input  logic                     sound_reset_n,
  input  logic                     push_i,
  input  speech_cmd_t              wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output speech_cmd_t              rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(Depth):0]   level_o
);

  localparam int unsigned AW = $clog2(Depth);
  localparam int unsigned LW = AW + 1;

  speech_cmd_t mem_q [Depth];
  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == LW'(Depth));
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; flush discards everything queued and beats a same-cycle push.
  always_ff @(posedge clk_1_5 or negedge sound_reset_n) begin
    if (!sound_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + LW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + LW'(1);
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk_1_5) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/tms5220_speech_sequencer.sv
// TMS5220 bus sequencer: queues CPU commands and runs the WSn/RSn/RDYn handshake.
module tms5220_speech_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned RDY_TIMEOUT = 255
) (
  input  logic                          clk_1_5,
  input  logic                          sound_reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_read,
  input  logic [7:0]                    cmd_data,
  input  logic                          flush,
  output logic                          rsp_valid,
  output logic [7:0]                    rsp_data,
  output logic                          rsp_err,
  input  logic                          err_clr,
  output logic                          timeout_err,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tms_wsn,
  output logic                          tms_rsn,
  output logic [7:0]                    tms_dbus_out,
  output logic                          tms_dbus_oe,
  input  logic [7:0]                    tms_dbus_in,
  input  logic                          tms_rdyn
);

  localparam int unsigned CW = $clog2(RDY_TIMEOUT + 1);

  speech_state_t state_q;
  speech_cmd_t   push_cmd, head, cmd_q;
  logic          fifo_full, fifo_empty, pop;
  logic          rdy_meta_q, rdy_s_q;
  logic [CW-1:0] tmo_cnt_q;

  assign push_cmd  = '{read: cmd_read, data: cmd_data};
  assign pop       = (state_q == StIdle) && !fifo_empty;
  assign cmd_ready = !fifo_full;
  assign busy      = (state_q != StIdle) || !fifo_empty;

  speech_cmd_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_1_5       (clk_1_5),
    .sound_reset_n (sound_reset_n),
    .push_i        (cmd_valid && cmd_ready),
    .wdata_i       (push_cmd),
    .pop_i         (pop),
    .flush_i       (flush),
    .rdata_o       (head),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .level_o       (fifo_level)
  );

  // Two-flop synchronizer for the chip's asynchronous ready (idles high).
  always_ff @(posedge clk_1_5 or negedge sound_reset_n) begin
    if (!sound_reset_n) begin
      rdy_meta_q <= 1'b1;
      rdy_s_q    <= 1'b1;
    end else begin
      rdy_meta_q <= tms_rdyn;
      rdy_s_q    <= rdy_meta_q;
    end
  end

  // Handshake FSM; every bus and response output is registered here.
  always_ff @(posedge clk_1_5 or negedge sound_reset_n) begin
    if (!sound_reset_n) begin
      state_q      <= StIdle;
      cmd_q        <= '0;
      tmo_cnt_q    <= '0;
      tms_wsn      <= 1'b1;
      tms_rsn      <= 1'b1;
      tms_dbus_oe  <= 1'b0;
      tms_dbus_out <= 8'h00;
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'h00;
      rsp_err      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      // A timeout set further down overrides this clear.
      if (err_clr) timeout_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!fifo_empty) begin
            cmd_q        <= head;
            tms_dbus_oe  <= !head.read;
            tms_dbus_out <= head.read ? 8'h00 : head.data;
            state_q      <= StSetup;
          end
        end
        StSetup: begin
          tms_wsn <= cmd_q.read;
          tms_rsn <= !cmd_q.read;
          state_q <= StStrobe;
        end
        StStrobe: begin
          tmo_cnt_q <= '0;
          state_q   <= StWaitRdy;
        end
        StWaitRdy: begin
          tmo_cnt_q <= tmo_cnt_q + CW'(1);
          if (!rdy_s_q) begin
            tms_wsn <= 1'b1;
            tms_rsn <= 1'b1;
            if (cmd_q.read) begin
              rsp_valid <= 1'b1;
              rsp_data  <= tms_dbus_in;
              rsp_err   <= 1'b0;
            end
            state_q <= StHold;
          end else if (tmo_cnt_q == CW'(RDY_TIMEOUT - 1)) begin
            // This is the RDY_TIMEOUT-th cycle spent waiting.
            tms_wsn     <= 1'b1;
            tms_rsn     <= 1'b1;
            timeout_err <= 1'b1;
            if (cmd_q.read) begin
              rsp_valid <= 1'b1;
              rsp_data  <= 8'h00;
              rsp_err   <= 1'b1;
            end
            state_q <= StAbort;
          end
        end
        StHold, StAbort: begin
          state_q <= StRecover;
        end
        StRecover: begin
          // Write data held through this cycle for chip hold time.
          tms_dbus_oe  <= 1'b0;
          tms_dbus_out <= 8'h00;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
